// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory port: size codes, FSM states,
// registered request fields and the alignment rule.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} lsu_state_e;

  // Byte offset is kept apart from the word address so the lane logic
  // never depends on ADDR_WIDTH.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_mem_port_if.sv
// CPU-side request/response bundle of the load/store memory port.
interface lsu_mem_port_if #(parameter int ADDR_WIDTH = 10);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and byte/half merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    lb      = word[{off, 3'b000} +: 8];
    lh      = word[{off[1], 4'b0000} +: 16];
    ld_data = word;
    st_data = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{lb[7] & ~uns}}, lb};
        st_data = word;
        st_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{lh[15] & ~uns}}, lh};
        st_data = word;
        st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: byte/half/word requests onto a word-wide memory with
// one-cycle read latency; sub-word stores are done as read-modify-write.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_mem_port_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_n,
  output logic                  mem_rd_n,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  lsu_state_e            state, state_nx;
  lsu_req_t              rq;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  accept, bad;
  logic [31:0]           ld_val, st_val;

  assign accept = bus.req_valid & (state == S_IDLE);
  assign bad    = misaligned(bus.req_size, bus.req_addr[1:0]);

  lsu_lane_align u_align (
    .word    (mem_rdata),
    .off     (rq.off),
    .size    (rq.size),
    .uns     (rq.uns),
    .wdata   (rq.wdata),
    .ld_data (ld_val),
    .st_data (st_val)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (bus.req_valid) begin
          if (bad)                                    state_nx = S_RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_nx = S_WRITE;
          else                                        state_nx = S_READ;
        end
      S_READ:  state_nx = S_CAPT;
      S_CAPT:  state_nx = rq.we ? S_WRITE : S_RESP;
      S_WRITE: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rq      <= '0;
      waddr   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rq    <= '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                   off: bus.req_addr[1:0], wdata: bus.req_wdata};
        waddr <= bus.req_addr[ADDR_WIDTH+1:2];
        if (bad) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else if (bus.req_we) begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
      end
      // The store-data field doubles as the merged word so WRITE has one source.
      if (state == S_CAPT) begin
        if (rq.we) rq.wdata <= st_val;
        else begin
          rdata_q <= ld_val;
          err_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Strobes are gated by rst_n so a reset edge can never commit a write.
  assign mem_rd_n  = rst_n & (state == S_READ);
  assign mem_wr_n  = rst_n & (state == S_WRITE);
  assign mem_addr  = (state == S_IDLE) ? '0 : waddr;
  assign mem_wdata = (state == S_WRITE) ? rq.wdata : '0;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized scoreboard bench for lsu_mem_port with a word-array memory model.
module tb_lsu_mem_port;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_n, mem_rd_n;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_WIDTH(AW)) bus ();

  lsu_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wr_n  (mem_wr_n),
    .mem_rd_n  (mem_rd_n),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            cyc;
    int            rd;
    int            wr;
    logic [AW-1:0] waddr;
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_acc = 0, n_resp = 0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory with registered read; write and read in one block keeps ordering fixed.
  always @(posedge clk) begin
    if (mem_rd_n) mem_rdata <= mem[mem_addr];
    if (mem_wr_n) mem[mem_addr] = mem_wdata;
  end

  // Monitor: checks ready, strobes and pops the scoreboard on each response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("req_ready", {31'b0, bus.req_ready}, {31'b0, (n_acc == n_resp)});
      if (mem_rd_n | mem_wr_n) begin
        check("strobe_excl", {31'b0, mem_rd_n & mem_wr_n}, 32'd0);
        if (q.size() > 0) check("mem_addr", {22'b0, mem_addr}, {22'b0, q[0].waddr});
      end
      rd_cnt += int'(mem_rd_n);
      wr_cnt += int'(mem_wr_n);
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          e = q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
          check("resp_latency", cyc, e.cyc);
          check("rd_strobes", rd_cnt, e.rd);
          check("wr_strobes", wr_cnt, e.wr);
        end
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        rd_cnt = 0;
        wr_cnt = 0;
        n_resp++;
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd);
    exp_t e;
    logic bad;
    logic [31:0] old, v, mask;
    int sh, lat, guard;
    bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    sh   = int'(a[1:0]) * 8;
    old  = ref_mem[a[AW+1:2]];
    e.waddr = a[AW+1:2];
    e.err = bad; e.rdata = '0; e.rd = 0; e.wr = 0;
    if (bad) lat = 1;
    else if (!we) begin
      v = old >> sh;
      if (sz == 2'd0) begin
        v &= 32'hFF;
        if (!uns && v[7]) v |= 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v &= 32'hFFFF;
        if (!uns && v[15]) v |= 32'hFFFF_0000;
      end
      e.rdata = v; e.rd = 1; lat = 3;
    end else begin
      mask = (sz == 2'd0) ? (32'hFF << sh) : (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
      ref_mem[a[AW+1:2]] = (old & ~mask) | ((wd << sh) & mask);
      e.wr = 1;
      e.rd = (sz == 2'd2) ? 0 : 1;
      lat  = (sz == 2'd2) ? 2 : 4;
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
      bus.req_valid = 1'b0;
    end else begin
      e.cyc = cyc + lat;
      q.push_back(e);
      @(posedge clk);
      n_acc++;
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (n_resp != n_acc && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", n_resp, n_acc);
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_strobes", {30'b0, mem_rd_n, mem_wr_n}, 32'd0);
    rst_n = 1'b1;

    // Sub-word loads with sign and zero extension.
    preload(3, 32'h8000_80F0);
    issue(1'b0, 2'b00, 1'b0, 12'h00C, 32'h0);
    wait_done();
    check("ld_byte_signed", last_rdata, 32'hFFFF_FFF0);
    issue(1'b0, 2'b01, 1'b1, 12'h00E, 32'h0);
    wait_done();
    check("ld_half_unsigned", last_rdata, 32'h0000_8000);
    issue(1'b0, 2'b01, 1'b0, 12'h00E, 32'h0);
    wait_done();
    check("ld_half_signed", last_rdata, 32'hFFFF_8000);

    // Byte store RMW.
    preload(3, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 12'h00D, 32'h0000_00AB);
    wait_done();
    check("st_byte_mem", mem[3], 32'h1122_AB44);
    check("st_byte_err", {31'b0, last_err}, 32'd0);

    // Word store followed immediately by word load.
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    wait_done();
    check("st_ld_word", last_rdata, 32'hDEAD_BEEF);

    // Misaligned requests.
    issue(1'b0, 2'b10, 1'b0, 12'h002, 32'h0);
    wait_done();
    check("misalign_ld_err", {31'b0, last_err}, 32'd1);
    check("misalign_ld_rdata", last_rdata, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 12'h005, 32'h0000_1234);
    wait_done();
    check("misalign_st_err", {31'b0, last_err}, 32'd1);

    // Reset landing on the WRITE edge of a byte RMW must leave memory intact.
    preload(3, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 12'h00D; bus.req_wdata = 32'h0000_00AB;
    @(posedge clk);
    n_acc++;
    #1 bus.req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_wr_n && guard < 10);
    check("rst_mid_wr_seen", {31'b0, mem_wr_n}, 32'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_wr_gated", {31'b0, mem_wr_n}, 32'd0);
    @(posedge clk);
    n_acc = n_resp;
    @(negedge clk);
    check("rst_mid_mem", mem[3], 32'h1122_3344);
    check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    rst_n = 1'b1;

    // Randomized traffic on a small address window to exercise RMW collisions.
    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_done();
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that sits between the CPU datapath and the word-wide single-port data memory.
- Accepts byte-addressed load/store requests of byte, half or word size and drives the memory address, write strobe and read strobe.
- Absorbs the memory's one-cycle registered read latency.
- Performs read-modify-write for sub-word stores and sign/zero-extends sub-word loads.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, memory word width; fixed at 32 in this revision.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address, little-endian lanes.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; qualified by resp_valid.
- mem_addr  out  ADDR_WIDTH  word address, equal to req_addr[ADDR_WIDTH+1:2].
- mem_wr_n  out  1  memory write strobe; 1 = write this edge.
- mem_rd_n  out  1  memory read strobe; 1 = read this edge.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after mem_rd_n=1.

Behaviour:
- States: IDLE, READ, CAPT, WRITE, RESP.
- req_ready = (state==IDLE). A handshake (req_valid & req_ready) at an edge registers addr, size, we, unsigned and wdata.
- Misalignment check on accept: half with addr[0]=1; word with addr[1:0]!=0; size 11. Any of these -> RESP with resp_err=1 and no memory strobe ever asserted.
- Load path: IDLE->READ->CAPT->RESP->IDLE.
  - READ drives mem_rd_n=1.
  - CAPT samples mem_rdata, extracts the lane, extends it and registers resp_rdata.
  - resp_valid is high in the 4th cycle counting the accept cycle as 1.
- Word store path: IDLE->WRITE->RESP. WRITE drives mem_wr_n=1 with mem_wdata=req_wdata.
- Sub-word store path: IDLE->READ->CAPT->WRITE->RESP.
  - CAPT registers merged data: the old word with only the addressed byte or half replaced.
  - WRITE drives mem_wr_n=1 with the merged data.
- Lane rules:
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
  - Sign extension replicates the lane MSB up to bit 31.
- mem_addr holds the registered word address in READ/CAPT/WRITE and 0 in IDLE. mem_wdata is 0 outside WRITE. mem_rd_n and mem_wr_n are never both 1.
- RESP lasts exactly one cycle, then returns to IDLE. A new request is accepted in the first IDLE cycle, so back-to-back throughput is one word store per 3 cycles.
- resp_rdata and resp_err hold their values until the next RESP. Both are cleared to 0 at the accept of a store.
- Reset: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, all registered request fields 0.
- mem_wr_n and mem_rd_n are gated combinationally with rst_n. An edge with rst_n=0 therefore never writes memory, even if the block was in WRITE. A reset mid-RMW aborts the store, and the old word is preserved.
- req_valid while not ready is ignored. The CPU must hold the request until accepted.

Decomposition:
- lsu_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The state enum.
  - A misalign-check function.
- One combinational sub-module, lsu_lane_align: inputs word, addr[1:0], size, unsigned and store data; outputs the extended load value and the merged store word. It is used in CAPT.

Test Plan:
- Memory word 3 = 32'h8000_80F0; load byte, unsigned=0, addr 0x0C -> resp_rdata 32'hFFFF_FFF0, resp_valid exactly 3 cycles after the accept cycle, one mem_rd_n pulse.
- Same word, load half unsigned at addr 0x0E -> 32'h0000_8000. Load half signed at 0x0E -> 32'hFFFF_8000.
- Store byte 0xAB at addr 0x0D onto 32'h1122_3344 -> memory word 3 = 32'h1122_AB44; sequence is one read strobe then one write strobe; resp_err=0.
- Word store 32'hDEAD_BEEF at addr 0x10 followed immediately by word load at 0x10 -> load returns 32'hDEAD_BEEF; req_ready is low during each busy state.
- Word load at addr 0x02, and half store at 0x05 -> resp_err=1, resp_rdata=0, no mem_rd_n or mem_wr_n asserted.
- Assert rst_n=0 for the edge where the state is WRITE in a byte store to word 3 (value 32'h1122_3344) -> memory word 3 stays 32'h1122_3344, state IDLE, resp_valid 0.
